cereal_rx: RTL
==============

// Module: cereal_rx
// PURPOSE
//   Serial receiver. Consumes the single-wire frame stream driven on out_fin by the
//   serial transmitter and rebuilds the 8-bit bytes. Received bytes go into a small
//   show-ahead FIFO. A downstream consumer (display latch, loopback checker) drains it.
//   Used on-board for loopback checking of the transmitter.
// PARAMETERS
//   CLKS_PER_BIT  434  sysclk cycles per serial bit (>=4); must match the transmitter
//   DEPTH         4    FIFO entries; power of 2, >=2
// PORTS
//   sysclk      in   1              system clock; all logic on rising edge
//   rst         in   1              synchronous, active-high reset
//   serial_in   in   1              async serial line; idle high
//   rd_en       in   1              pop head of FIFO when data_valid=1
//   data_out    out  8              FIFO head byte (show-ahead); 8'h00 when empty
//   data_valid  out  1              FIFO not empty
//   frame_err   out  1              1-cycle pulse: stop bit sampled low, byte dropped
//   overflow    out  1              sticky: a good byte was dropped because FIFO full
//   busy        out  1              FSM not in IDLE
//   count       out  $clog2(DEPTH)+1  bytes currently held in FIFO
// BEHAVIOUR
//   Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
//   Input synchroniser
//   - serial_in passes through 2 flops (both reset to 1) giving rx_s.
//   - FSM sees line edges 2 cycles late.
//   Bit counter
//   - clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..7.
//   FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Reset -> IDLE, clk_cnt=0, bit_idx=0.
//   - IDLE: when rx_s==0, go to START with clk_cnt=0.
//   - START: at clk_cnt==CLKS_PER_BIT/2-1, re-check rx_s (mid-bit).
//       rx_s==1: glitch; return to IDLE with nothing pushed.
//       rx_s==0: clk_cnt=0, go to DATA.
//   - DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx].
//       After bit_idx==7 is sampled, go to STOP.
//   - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
//       rx_s==1: push shreg, go to IDLE.
//       rx_s==0: pulse frame_err for 1 cycle, drop the byte, go to WAIT_IDLE.
//   - WAIT_IDLE: stay until rx_s==1, then go to IDLE. Break or stuck-low never yields bytes.
//   Latency
//   - The push is registered on the stop-sample cycle.
//   - data_valid/data_out update on the next edge.
//   FIFO
//   - Circular buffer. Pointers are $clog2(DEPTH) bits and wrap naturally. Separate count register.
//   - Pop: rd_en && data_valid. rd_en while empty is ignored; no underflow.
//   - Push while full, no pop that cycle: byte dropped, overflow set to 1. Cleared only by rst.
//   - Push and pop in the same cycle, including when full: both occur and count is unchanged.
//   Reset values: data_out=0, data_valid=0, frame_err=0, overflow=0, busy=0, count=0.
//   Reset mid-frame: state, pointers, count, flags and shreg all cleared. The remainder
//     of that frame is treated as line activity; if a later low bit is seen it may start
//     a spurious frame, which then ends in frame_err or a garbage byte. Acceptable.
// TESTING  (CLKS_PER_BIT=16, DEPTH=4)
//   1. Drive frame 8'hA5 -> data_valid rises 1 cycle after stop sample; data_out=8'hA5;
//      count=1; no frame_err.
//   2. Send 8'h01,8'h80,8'hFF,8'h00 with no rd_en, then a 5th byte 8'h3C -> count=4 and
//      overflow=1. Pops return 01,80,FF,00 in order; 3C is absent.
//   3. Hold FIFO full, assert rd_en on the cycle of 5th stop sample -> count stays 4,
//      overflow=0, new byte at tail.
//   4. Frame 8'h5A with stop bit driven 0 -> frame_err single-cycle pulse, count
//      unchanged. Line held low 40 cycles then high -> FSM returns to IDLE.
//      Next frame 8'h5A is received correctly.
//   5. Low glitch of 5 cycles on idle line -> FSM returns to IDLE; no push, no frame_err.
//   6. Assert rst for 1 cycle mid-DATA of a frame -> all outputs at reset values the
//      next cycle. A following clean frame 8'hC3 is received.

Source files
------------

// File: rtl/cereal_rx.sv
// Serial receiver: 8N1 frames sampled from an idle-high line, bytes queued in a
// small show-ahead FIFO for a downstream consumer.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | line idle, waiting for a falling edge on rx_s
// S_START    | half a bit into the start bit, confirming it is still low
// S_DATA     | sampling 8 data bits LSB first at the end of each bit period
// S_STOP     | sampling the stop bit; high pushes the byte, low flags an error
// S_WAIT_IDLE| framing error seen, holding off until the line returns high
module cereal_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic                     rd_en,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    output logic                     frame_err,
    output logic                     overflow,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic            sync1_q, sync2_q;
    logic            rx_s;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            push_q, push_d;
    logic            ferr_q, ferr_d;

    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            ovf_q;

    logic            pop;
    logic            full;
    logic            wr;

    assign rx_s = sync2_q;

    // Two-flop synchroniser on the asynchronous line; resets to the idle level.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // Receiver FSM and bit-timing registers.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: start confirmation at mid-bit, data/stop sampled at bit end.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop  = rd_en && (count_q != '0);
    assign full = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr   = push_q && (!full || pop);

    // FIFO storage; contents need no reset because data_out is masked when empty.
    always_ff @(posedge sysclk) begin
        if (wr) mem_q[wr_ptr_q] <= shreg_q;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (wr && !pop)      count_q <= count_q + CNTW'(1);
            else if (!wr && pop) count_q <= count_q - CNTW'(1);
            if (push_q && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign data_valid = (count_q != '0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE);
    assign count      = count_q;

endmodule
